ram_arbiter: RTL

- Two-requester round-robin arbiter and access sequencer for the single-port asynchronous Ram block (Addr, DataIn, RWS, CS, DataOut).
- Each requester issues read/write transactions over a req/ack handshake.
- The block serialises them onto the Ram pins with glitch-free registered strobes and returns read data.
- Sits between the Ram instance and the client logic; the only driver of the Ram control pins.

---
 rtl/ram_arbiter_if.sv | 58 +++++
 rtl/ram_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bundles the two requester handshakes and the Ram pins of ram_arbiter.
// RAM_ARB_STATS_EN adds the Cnt0/Cnt1/Conflict statistics signals.
interface ram_arbiter_if #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 8
);
  logic                 Req0;
  logic                 Wr0;
  logic [AddrWidth-1:0] Addr0;
  logic [DataWidth-1:0] WData0;
  logic                 Ack0;
  logic [DataWidth-1:0] RData0;

  logic                 Req1;
  logic                 Wr1;
  logic [AddrWidth-1:0] Addr1;
  logic [DataWidth-1:0] WData1;
  logic                 Ack1;
  logic [DataWidth-1:0] RData1;

  logic [1:0]           Gnt;

  logic [AddrWidth-1:0] RamAddr;
  logic [DataWidth-1:0] RamDataIn;
  logic                 RamRWS;
  logic                 RamCS;
  logic [DataWidth-1:0] RamDataOut;

`ifdef RAM_ARB_STATS_EN
  logic [15:0]          Cnt0;
  logic [15:0]          Cnt1;
  logic                 Conflict;
`endif

  // Client side: requesters plus the Ram instance.
  modport master (
    output Req0, Wr0, Addr0, WData0,
    output Req1, Wr1, Addr1, WData1,
    input  Ack0, RData0, Ack1, RData1, Gnt,
    input  RamAddr, RamDataIn, RamRWS, RamCS,
    output RamDataOut
`ifdef RAM_ARB_STATS_EN
    , input Cnt0, Cnt1, Conflict
`endif
  );

  // Arbiter side.
  modport slave (
    input  Req0, Wr0, Addr0, WData0,
    input  Req1, Wr1, Addr1, WData1,
    output Ack0, RData0, Ack1, RData1, Gnt,
    output RamAddr, RamDataIn, RamRWS, RamCS,
    input  RamDataOut
`ifdef RAM_ARB_STATS_EN
    , output Cnt0, Cnt1, Conflict
`endif
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter sequencing accesses onto a single-port async Ram.
// Optional RAM_ARB_STATS_EN adds saturating per-requester counters and a Conflict pulse.
module ram_arbiter #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 8
) (
  input logic          Clk,
  input logic          Rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} stateT;

  stateT                stateQ, stateD;
  logic                 ownerQ, ownerD;
  logic                 lastGntQ, lastGntD;
  logic [1:0]           gntQ, gntD;
  logic [AddrWidth-1:0] ramAddrQ, ramAddrD;
  logic [DataWidth-1:0] ramDataInQ, ramDataInD;
  logic                 ramRwsQ, ramRwsD;
  logic                 ramCsQ, ramCsD;
  logic                 ack0Q, ack0D;
  logic                 ack1Q, ack1D;
  logic [DataWidth-1:0] rData0Q, rData0D;
  logic [DataWidth-1:0] rData1Q, rData1D;
  logic                 winner;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]          cnt0Q, cnt0D;
  logic [15:0]          cnt1Q, cnt1D;
  logic                 conflictQ, conflictD;
`endif

  always_comb begin
    stateD     = stateQ;
    ownerD     = ownerQ;
    lastGntD   = lastGntQ;
    gntD       = gntQ;
    ramAddrD   = ramAddrQ;
    ramDataInD = ramDataInQ;
    ramRwsD    = ramRwsQ;
    ramCsD     = 1'b0;
    ack0D      = 1'b0;
    ack1D      = 1'b0;
    rData0D    = rData0Q;
    rData1D    = rData1Q;
    winner     = 1'b0;
`ifdef RAM_ARB_STATS_EN
    cnt0D      = cnt0Q;
    cnt1D      = cnt1Q;
    conflictD  = 1'b0;
`endif

    unique case (stateQ)
      StIdle: begin
        // On a tie the requester that did not own the previous access wins.
        winner = (bus.Req0 && bus.Req1) ? ~lastGntQ : bus.Req1;
        if (bus.Req0 || bus.Req1) begin
          stateD     = StSetup;
          ownerD     = winner;
          gntD       = winner ? 2'b10 : 2'b01;
          ramAddrD   = winner ? bus.Addr1 : bus.Addr0;
          ramDataInD = winner ? bus.WData1 : bus.WData0;
          ramRwsD    = winner ? bus.Wr1 : bus.Wr0;
`ifdef RAM_ARB_STATS_EN
          conflictD  = bus.Req0 && bus.Req1;
`endif
        end
      end
      StSetup: begin
        ramCsD = 1'b1;
        stateD = StStrobe;
      end
      StStrobe: begin
        // Ram output is sampled while CS is still asserted.
        if (!ramRwsQ) begin
          if (ownerQ) rData1D = bus.RamDataOut;
          else        rData0D = bus.RamDataOut;
        end
        ack0D  = ~ownerQ;
        ack1D  = ownerQ;
        stateD = StHold;
      end
      StHold: begin
        lastGntD = ownerQ;
        gntD     = 2'b00;
        stateD   = StIdle;
`ifdef RAM_ARB_STATS_EN
        if (!ownerQ && cnt0Q != 16'hFFFF) cnt0D = cnt0Q + 16'd1;
        if (ownerQ && cnt1Q != 16'hFFFF)  cnt1D = cnt1Q + 16'd1;
`endif
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateQ     <= StIdle;
      ownerQ     <= 1'b0;
      lastGntQ   <= 1'b1;
      gntQ       <= 2'b00;
      ramAddrQ   <= '0;
      ramDataInQ <= '0;
      ramRwsQ    <= 1'b0;
      ramCsQ     <= 1'b0;
      ack0Q      <= 1'b0;
      ack1Q      <= 1'b0;
      rData0Q    <= '0;
      rData1Q    <= '0;
`ifdef RAM_ARB_STATS_EN
      cnt0Q      <= 16'd0;
      cnt1Q      <= 16'd0;
      conflictQ  <= 1'b0;
`endif
    end else begin
      stateQ     <= stateD;
      ownerQ     <= ownerD;
      lastGntQ   <= lastGntD;
      gntQ       <= gntD;
      ramAddrQ   <= ramAddrD;
      ramDataInQ <= ramDataInD;
      ramRwsQ    <= ramRwsD;
      ramCsQ     <= ramCsD;
      ack0Q      <= ack0D;
      ack1Q      <= ack1D;
      rData0Q    <= rData0D;
      rData1Q    <= rData1D;
`ifdef RAM_ARB_STATS_EN
      cnt0Q      <= cnt0D;
      cnt1Q      <= cnt1D;
      conflictQ  <= conflictD;
`endif
    end
  end

  assign bus.Ack0      = ack0Q;
  assign bus.Ack1      = ack1Q;
  assign bus.RData0    = rData0Q;
  assign bus.RData1    = rData1Q;
  assign bus.Gnt       = gntQ;
  assign bus.RamAddr   = ramAddrQ;
  assign bus.RamDataIn = ramDataInQ;
  assign bus.RamRWS    = ramRwsQ;
  assign bus.RamCS     = ramCsQ;
`ifdef RAM_ARB_STATS_EN
  assign bus.Cnt0      = cnt0Q;
  assign bus.Cnt1      = cnt1Q;
  assign bus.Conflict  = conflictQ;
`endif

endmodule
